// File: rtl/soml_min_search_if.sv
// soml_min_search_if
// Groups the request, received-block, ROM-address/data and result signals of
// the SOML minimum-distance search. The host/testbench side (which also
// models the combinational candidate ROM) uses the master modport. The
// search engine uses the slave modport.
interface soml_min_search_if #(
  parameter int W      = 16,
  parameter int LANES  = 4,
  parameter int N_CAND = 16,
  parameter int MW     = 40
);
  localparam int IW = $clog2(N_CAND);
  localparam int CW = W * LANES;

  logic          start;
  logic [CW-1:0] y0_r;
  logic [CW-1:0] y0_i;
  logic [CW-1:0] y1_r;
  logic [CW-1:0] y1_i;
  logic [IW-1:0] rom_si;
  logic [1:0]    rom_col;
  logic [CW-1:0] rom_r;
  logic [CW-1:0] rom_i;
  logic          busy;
  logic          done;
  logic [IW-1:0] best_idx;
  logic [MW-1:0] best_metric;

  modport master (
    output start, y0_r, y0_i, y1_r, y1_i, rom_r, rom_i,
    input  rom_si, rom_col, busy, done, best_idx, best_metric
  );

  modport slave (
    input  start, y0_r, y0_i, y1_r, y1_i, rom_r, rom_i,
    output rom_si, rom_col, busy, done, best_idx, best_metric
  );
endinterface

// File: rtl/soml_min_search.sv
// soml_min_search
// Sweeps every candidate of the SOML candidate-symbol ROM (two columns per
// candidate) and finds the candidate with the smallest squared Euclidean
// distance to the latched received block. Reports the winning index and
// its metric with a one-cycle done pulse.
//
// Optional build macro: SOML_MIN_PIPE_EN
//   Defined   : ROM data and the selected received column are registered
//               before the distance logic. The address runs one cycle ahead
//               of the compare, and one drain cycle follows the last address.
//               done arrives one cycle later than in the default build, and
//               the results are identical.
//   Undefined : ROM data feeds the distance logic combinationally.
module soml_min_search #(
  parameter int W      = 16,
  parameter int LANES  = 4,
  parameter int N_CAND = 16,
  parameter int MW     = 40
) (
  input logic              clk,
  input logic              rst_n,
  soml_min_search_if.slave bus
);

  localparam int IW  = $clog2(N_CAND);
  localparam int CW  = W * LANES;
  localparam int SQW = 2 * W + 2;
  localparam logic [IW-1:0] LAST_SI = IW'(N_CAND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic          w_busy;
  logic          w_done;
  logic          w_start;
  logic          w_lastAddr;

  logic [IW-1:0] r_romSi;
  logic          r_romCol;

  logic [CW-1:0] r_y0R;
  logic [CW-1:0] r_y0I;
  logic [CW-1:0] r_y1R;
  logic [CW-1:0] r_y1I;
  logic [CW-1:0] w_ySelR;
  logic [CW-1:0] w_ySelI;

  logic          w_dValid;
  logic          w_dCol;
  logic [IW-1:0] w_dSi;
  logic [CW-1:0] w_dYR;
  logic [CW-1:0] w_dYI;
  logic [CW-1:0] w_dRomR;
  logic [CW-1:0] w_dRomI;

  logic [MW-1:0] w_colDist;
  logic [MW-1:0] w_candMetric;
  logic          w_better;
  logic          w_sweepEnd;

  logic [MW-1:0] r_acc;
  logic [MW-1:0] r_bestMetric;
  logic [IW-1:0] r_bestIdx;
  logic [MW-1:0] r_bestMetricOut;
  logic [IW-1:0] r_bestIdxOut;

  assign w_start    = bus.start && (r_state == S_IDLE);
  assign w_lastAddr = (r_romSi == LAST_SI) && r_romCol;

  // State register; a low rst_n at the clock edge aborts any sweep
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status decode: busy covers the sweep, done is the single result cycle
  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_lastAddr) begin
`ifdef SOML_MIN_PIPE_EN
          w_stateNext = S_DRAIN;
`else
          w_stateNext = S_DONE;
`endif
        end
      end
      S_DRAIN: begin
        w_busy      = 1'b1;
        w_stateNext = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // ROM address walk (0,0),(0,1),(1,0)...; parked at zero whenever not sweeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_romSi  <= '0;
      r_romCol <= 1'b0;
    end else if ((r_state == S_RUN) && !w_lastAddr) begin
      r_romCol <= ~r_romCol;
      if (r_romCol) begin
        r_romSi <= r_romSi + 1'b1;
      end
    end else begin
      r_romSi  <= '0;
      r_romCol <= 1'b0;
    end
  end

  // Capture the received block when a request is accepted so the front end may move on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y0R <= '0;
      r_y0I <= '0;
      r_y1R <= '0;
      r_y1I <= '0;
    end else if (w_start) begin
      r_y0R <= bus.y0_r;
      r_y0I <= bus.y0_i;
      r_y1R <= bus.y1_r;
      r_y1I <= bus.y1_i;
    end
  end

  assign w_ySelR = r_romCol ? r_y1R : r_y0R;
  assign w_ySelI = r_romCol ? r_y1I : r_y0I;

`ifdef SOML_MIN_PIPE_EN
  logic          r_pValid;
  logic          r_pCol;
  logic [IW-1:0] r_pSi;
  logic [CW-1:0] r_pYR;
  logic [CW-1:0] r_pYI;
  logic [CW-1:0] r_pRomR;
  logic [CW-1:0] r_pRomI;

  // Register ROM data, the matching received column and the address tag ahead of the distance logic
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pValid <= 1'b0;
      r_pCol   <= 1'b0;
      r_pSi    <= '0;
      r_pYR    <= '0;
      r_pYI    <= '0;
      r_pRomR  <= '0;
      r_pRomI  <= '0;
    end else begin
      r_pValid <= (r_state == S_RUN);
      r_pCol   <= r_romCol;
      r_pSi    <= r_romSi;
      r_pYR    <= w_ySelR;
      r_pYI    <= w_ySelI;
      r_pRomR  <= bus.rom_r;
      r_pRomI  <= bus.rom_i;
    end
  end

  assign w_dValid = r_pValid;
  assign w_dCol   = r_pCol;
  assign w_dSi    = r_pSi;
  assign w_dYR    = r_pYR;
  assign w_dYI    = r_pYI;
  assign w_dRomR  = r_pRomR;
  assign w_dRomI  = r_pRomI;
`else
  assign w_dValid = (r_state == S_RUN);
  assign w_dCol   = r_romCol;
  assign w_dSi    = r_romSi;
  assign w_dYR    = w_ySelR;
  assign w_dYI    = w_ySelI;
  assign w_dRomR  = bus.rom_r;
  assign w_dRomI  = bus.rom_i;
`endif

  // Column distance: widen each lane by one bit so the difference never wraps, then sum exact squares
  always_comb begin : colDistance
    logic signed [W:0]     diffR;
    logic signed [W:0]     diffI;
    logic signed [SQW-1:0] extR;
    logic signed [SQW-1:0] extI;
    logic [SQW-1:0]        sqR;
    logic [SQW-1:0]        sqI;
    diffR     = '0;
    diffI     = '0;
    extR      = '0;
    extI      = '0;
    sqR       = '0;
    sqI       = '0;
    w_colDist = '0;
    for (int k = 0; k < LANES; k++) begin
      diffR = $signed({w_dYR[W*k+W-1], w_dYR[W*k +: W]})
            - $signed({w_dRomR[W*k+W-1], w_dRomR[W*k +: W]});
      diffI = $signed({w_dYI[W*k+W-1], w_dYI[W*k +: W]})
            - $signed({w_dRomI[W*k+W-1], w_dRomI[W*k +: W]});
      extR  = {{(W+1){diffR[W]}}, diffR};
      extI  = {{(W+1){diffI[W]}}, diffI};
      sqR   = extR * extR;
      sqI   = extI * extI;
      w_colDist = w_colDist
                + {{(MW-SQW){1'b0}}, sqR}
                + {{(MW-SQW){1'b0}}, sqI};
    end
  end

  assign w_candMetric = r_acc + w_colDist;
  assign w_better     = w_candMetric < r_bestMetric;
  assign w_sweepEnd   = w_dValid && w_dCol && (w_dSi == LAST_SI);

  // Column-0 distance is parked in the accumulator; column 1 completes the candidate and competes for best
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_bestMetric <= '0;
      r_bestIdx    <= '0;
    end else if (w_start) begin
      r_acc        <= '0;
      r_bestMetric <= '1;
      r_bestIdx    <= '0;
    end else if (w_dValid) begin
      if (!w_dCol) begin
        r_acc <= w_colDist;
      end else if (w_better) begin
        r_bestMetric <= w_candMetric;
        r_bestIdx    <= w_dSi;
      end
    end
  end

  // Publish the final winner as the last candidate is judged so it is stable through the done cycle and after
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bestMetricOut <= '0;
      r_bestIdxOut    <= '0;
    end else if (w_sweepEnd) begin
      if (w_better) begin
        r_bestMetricOut <= w_candMetric;
        r_bestIdxOut    <= w_dSi;
      end else begin
        r_bestMetricOut <= r_bestMetric;
        r_bestIdxOut    <= r_bestIdx;
      end
    end
  end

  assign bus.rom_si      = r_romSi;
  assign bus.rom_col     = {1'b0, r_romCol};
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.best_idx    = r_bestIdxOut;
  assign bus.best_metric = r_bestMetricOut;

endmodule

// File: tb/tb_soml_min_search.sv
// tb_soml_min_search
// Self-checking bench for soml_min_search. Models the candidate ROM
// combinationally, computes expected winners with a 64-bit reference search,
// and matches them against each done pulse through a scoreboard queue.
// Build with SOML_MIN_PIPE_EN defined to check the pipelined variant.
module tb_soml_min_search;

  localparam int W      = 16;
  localparam int LANES  = 4;
  localparam int N_CAND = 16;
  localparam int MW     = 40;

  // done is observed after edge k+LATENCY, i.e. in cycle k+33 (k+34 pipelined)
`ifdef SOML_MIN_PIPE_EN
  localparam int LATENCY = 33;
`else
  localparam int LATENCY = 32;
`endif

  typedef struct {
    int     idx;
    longint metric;
    int     acceptEdge;
  } exp_t;

  logic clk;
  logic rst_n;

  soml_min_search_if #(.W(W), .LANES(LANES), .N_CAND(N_CAND), .MW(MW)) bus ();

  soml_min_search #(.W(W), .LANES(LANES), .N_CAND(N_CAND), .MW(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [63:0] romR [0:15][0:1];
  logic [63:0] romI [0:15][0:1];

  exp_t sbQ[$];
  exp_t sbHead;
  int   checkCount = 0;
  int   passCount  = 0;
  int   doneCount  = 0;
  int   cycleCnt   = 0;
  bit   prevDone   = 1'b0;

  assign bus.rom_r = romR[bus.rom_si][bus.rom_col[0]];
  assign bus.rom_i = romI[bus.rom_si][bus.rom_col[0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint expv);
    checkCount++;
    if (obs == expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Candidates 0..3 are all at distance 32768 from the tie stimulus; 9 is a fixed pattern
  task automatic buildRom();
    logic [15:0] lane;
    for (int c = 0; c < N_CAND; c++) begin
      romR[c][0] = 64'hff800080ff800000;
      romR[c][1] = 64'hff80ff80ff800000;
      romI[c][1] = 64'h0;
      for (int j = 0; j < LANES; j++) begin
        lane = c[j] ? 16'h0080 : 16'hff80;
        romI[c][0][16*j +: 16] = lane;
      end
    end
    romR[0][0] = 64'h0080ff8000000000; romI[0][0] = 64'h0;
    romR[0][1] = 64'h0080008000000000; romI[0][1] = 64'h0;
    romR[1][0] = 64'h0080ff8000800000; romI[1][0] = 64'h0000000000000080;
    romR[1][1] = 64'h0080008000000080; romI[1][1] = 64'h0000000000800000;
    romR[2][0] = 64'h0080ff8000800000; romI[2][0] = 64'hff80000000000000;
    romR[2][1] = 64'h0080008000000080; romI[2][1] = 64'h0000ff8000000000;
    romR[3][0] = 64'h0000ff8000800000; romI[3][0] = 64'h0;
    romR[3][1] = 64'h0080008000000080; romI[3][1] = 64'h0000000000000080;
    romR[9][0] = 64'h0080ff8000000000; romI[9][0] = 64'h0000000000800080;
    romR[9][1] = 64'h0080008000000000; romI[9][1] = 64'h0000000000800080;
  endtask

  task automatic goldenSearch(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d,
                              output int idx, output longint metric);
    longint m;
    longint dr;
    longint di;
    logic [63:0] yr;
    logic [63:0] yi;
    metric = 64'sh7fffffffffffffff;
    idx    = 0;
    for (int s = 0; s < N_CAND; s++) begin
      m = 0;
      for (int col = 0; col < 2; col++) begin
        yr = (col == 0) ? a : c;
        yi = (col == 0) ? b : d;
        for (int k = 0; k < LANES; k++) begin
          dr = longint'($signed(yr[16*k +: 16])) - longint'($signed(romR[s][col][16*k +: 16]));
          di = longint'($signed(yi[16*k +: 16])) - longint'($signed(romI[s][col][16*k +: 16]));
          m  = m + dr * dr + di * di;
        end
      end
      if (m < metric) begin
        metric = m;
        idx    = s;
      end
    end
  endtask

  // expIdx < 0 selects the reference search; push = 0 drives a request that must not complete
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [63:0] d,
                               input int expIdx, input longint expMetric, input bit push);
    exp_t e;
    bus.y0_r = a;
    bus.y0_i = b;
    bus.y1_r = c;
    bus.y1_i = d;
    if (expIdx < 0) begin
      goldenSearch(a, b, c, d, e.idx, e.metric);
    end else begin
      e.idx    = expIdx;
      e.metric = expMetric;
    end
    @(negedge clk);
    bus.start = 1'b1;
    e.acceptEdge = cycleCnt + 1;
    if (push) sbQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    if (push) checkOutput("busy_after_start", longint'(bus.busy), 1);
  endtask

  task automatic waitDone(input int base);
    int i;
    i = 0;
    while (doneCount == base && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (doneCount == base) checkOutput("done_timeout", doneCount, base + 1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (bus.done) begin
      doneCount = doneCount + 1;
      checkOutput("done_single", longint'(prevDone), 0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        sbHead = sbQ.pop_front();
        checkOutput("best_idx", longint'(bus.best_idx), sbHead.idx);
        checkOutput("best_metric", longint'(bus.best_metric), sbHead.metric);
        checkOutput("done_latency", cycleCnt - sbHead.acceptEdge, LATENCY);
      end
    end
    prevDone = bus.done;
  end

  initial begin
    int base;
    int i;
    buildRom();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.y0_r  = '0;
    bus.y0_i  = '0;
    bus.y1_r  = '0;
    bus.y1_i  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", longint'(bus.busy), 0);
    checkOutput("rst_done", longint'(bus.done), 0);
    checkOutput("rst_best_idx", longint'(bus.best_idx), 0);
    checkOutput("rst_best_metric", longint'(bus.best_metric), 0);
    checkOutput("rst_rom_si", longint'(bus.rom_si), 0);
    checkOutput("rst_rom_col", longint'(bus.rom_col), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] exact candidate 0");
    base = doneCount;
    applyStimulus(64'h0080ff8000000000, 64'h0, 64'h0080008000000000, 64'h0, 0, 0, 1'b1);
    waitDone(base);

    $display("[TB] exact candidate 9");
    base = doneCount;
    applyStimulus(64'h0080ff8000000000, 64'h0000000000800080,
                  64'h0080008000000000, 64'h0000000000800080, 9, 0, 1'b1);
    waitDone(base);

    $display("[TB] tie between candidates 0..3");
    base = doneCount;
    applyStimulus(64'h0080ff8000800000, 64'h0, 64'h0080008000000080, 64'h0, 0, 32768, 1'b1);
    waitDone(base);

    $display("[TB] most negative samples on every lane");
    base = doneCount;
    applyStimulus(64'h8000800080008000, 64'h8000800080008000,
                  64'h8000800080008000, 64'h8000800080008000, -1, 0, 1'b1);
    waitDone(base);

    $display("[TB] random received blocks");
    for (int r = 0; r < 3; r++) begin
      base = doneCount;
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, -1, 0, 1'b1);
      waitDone(base);
    end

    $display("[TB] reset during sweep");
    base = doneCount;
    applyStimulus(64'h0080ff8000800000, 64'h0, 64'h0080008000000080, 64'h0, -1, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", longint'(bus.busy), 0);
    checkOutput("abort_done", longint'(bus.done), 0);
    checkOutput("abort_best_idx", longint'(bus.best_idx), 0);
    checkOutput("abort_best_metric", longint'(bus.best_metric), 0);
    checkOutput("abort_rom_si", longint'(bus.rom_si), 0);
    checkOutput("abort_rom_col", longint'(bus.rom_col), 0);
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", doneCount, base);
    applyStimulus(64'h0080ff8000000000, 64'h0000000000800080,
                  64'h0080008000000000, 64'h0000000000800080, 9, 0, 1'b1);
    waitDone(base);

    $display("[TB] start while busy");
    base = doneCount;
    applyStimulus(64'h0080ff8000000000, 64'h0000000000800080,
                  64'h0080008000000000, 64'h0000000000800080, 9, 0, 1'b1);
    repeat (4) @(negedge clk);
    bus.y0_r  = 64'h0080ff8000000000;
    bus.y0_i  = 64'h0;
    bus.y1_r  = 64'h0080008000000000;
    bus.y1_i  = 64'h0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(base);
    repeat (40) @(negedge clk);
    checkOutput("busy_start_single_done", doneCount, base + 1);

    $display("[TB] start during done cycle");
    applyStimulus(64'h0080ff8000800000, 64'h0, 64'h0080008000000080, 64'h0, 0, 32768, 1'b1);
    i = 0;
    while (!bus.done && i < 100) begin
      @(negedge clk);
      i++;
    end
    checkOutput("done_seen", longint'(bus.done), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("start_in_done_ignored", longint'(bus.busy), 0);
    repeat (40) @(negedge clk);
    checkOutput("done_start_no_sweep", longint'(bus.busy), 0);
    checkOutput("sb_empty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/soml_min_search.md
Name: soml_min_search

Overview:
- Downstream consumer of the SOML candidate-symbol ROM.
- Sweeps all candidate indices and both columns by driving the ROM address. Computes the squared Euclidean distance between the received 2-column complex block and each candidate, then reports the minimum-distance index and its metric.
- Sits between the equalised-sample front end and the bit demapper in the SOML decoder.

Parameters:
- W, 16, lane sample width, signed two's complement, same Q format as ROM entries (0x0080 = +1).
- LANES, 4, complex lanes per column; a 64-bit column word holds lane k in bits [W*k+W-1 : W*k].
- N_CAND, 16, number of candidates; index width 4.
- MW, 40, metric width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- y0_r, y0_i  in  64 each  received column 0, real/imag, LANES×W packed.
- y1_r, y1_i  in  64 each  received column 1, real/imag.
- rom_si  out  4  candidate index to ROM.
- rom_col  out  2  column select to ROM; bit 1 always 0.
- rom_r, rom_i  in  64 each  ROM column data, combinational from rom_si/rom_col.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when result is valid.
- best_idx  out  4  minimum-metric candidate index.
- best_metric  out  MW  its metric.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; busy=0, done=0, best_idx=0, best_metric=0, rom_si=0, rom_col=0, internal accumulators cleared. Reset mid-sweep aborts with no done pulse.
- States:
  - IDLE: on start accepted at edge k, latch y0/y1, set rom_si=0, rom_col=0, load running best to all-ones, go to RUN. busy=1 from cycle k+1.
  - RUN: one ROM column per cycle. Column distance d = sum over lanes of (y_r−rom_r)^2 + (y_i−rom_i)^2, using y0 when rom_col=0 and y1 when rom_col=1.
    - Differences are computed at W+1 bits signed and squares at 2W+2 unsigned, zero-extended to MW; no saturation is needed at MW=40.
    - rom_col=0: acc <= d.
    - rom_col=1: m = acc + d. If m < running best (strict), update best and best index to rom_si; equal metrics keep the lower index.
    - Address order: (0,0),(0,1),(1,0),…,(15,1). After (15,1), go to DONE.
  - DONE: drive best_idx/best_metric from the running best, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge k, 32 RUN cycles (k+1..k+32), done high in cycle k+33.
- best_idx/best_metric hold their values until the next DONE.
- start while busy=1 is ignored, with no queuing.
- start in the same cycle as DONE is ignored.
- rom_si/rom_col hold 0 in IDLE.

Optional Feature:
- SOML_MIN_PIPE_EN defined:
  - rom_r/rom_i and the selected y column are registered before the distance logic.
  - The address runs one cycle ahead of the compare, with one extra drain cycle after (15,1).
  - done is high in cycle k+34. Results are identical to the non-pipelined build.
- Not defined: purely combinational ROM-to-distance path, with done in cycle k+33.

Test Plan:
- y = candidate 0 columns exactly, imag 0 → best_idx=0, best_metric=0, done pulse exactly 33 cycles after start.
- y = candidate 9 columns (col0 r=0x0080ff8000000000 i=0x0000000000800080; col1 r=0x0080008000000000 i=0x0000000000800080) → best_idx=9, best_metric=0.
- Tie: y_r = candidate 1 real columns (0x0080ff8000800000, 0x0080008000000080), y_i=0 → candidates 0,1,2,3 all give 32768 → best_idx=0, best_metric=32768.
- All lanes of y = 0x8000 real and imag → best_metric matches a 64-bit golden model with no wrap, and best_idx matches the golden model.
- Assert rst_n=0 at RUN cycle 10, release → no done, busy=0, outputs 0. Then start again → correct result after 33 cycles.
- Pulse start again at cycle k+5 while busy → ignored; a single done occurs at k+33 with the first request's result. Rerun with SOML_MIN_PIPE_EN defined → done at k+34, identical results.
